// File: rtl/exe_stage_mc.sv
// Execute stage: single-cycle ALU, branch-target adder, NZCV status register and an
// iterative shift-add multiplier (MUL/MLA) that stalls the front of the pipeline.
module exe_stage_mc #(
    parameter int unsigned DATA_LEN    = 32,
    parameter int unsigned ADDRESS_LEN = 32,
    parameter int unsigned MUL_STEP    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic                   flush,
    input  logic [ADDRESS_LEN-1:0] PC_in,
    input  logic [3:0]             EXE_CMD,
    input  logic                   is_mul,
    input  logic                   is_mla,
    input  logic [DATA_LEN-1:0]    Val_Rn,
    input  logic [DATA_LEN-1:0]    Val2,
    input  logic [DATA_LEN-1:0]    Val_Acc,
    input  logic                   carry_in,
    input  logic                   S,
    input  logic [23:0]            Signed_imm_24,
    output logic [DATA_LEN-1:0]    ALU_Res,
    output logic                   res_valid,
    output logic                   stall,
    output logic [ADDRESS_LEN-1:0] Branch_Address,
    output logic                   N_stat,
    output logic                   Z_stat,
    output logic                   C_stat,
    output logic                   V_stat
);

    localparam int unsigned NumSteps = DATA_LEN / MUL_STEP;
    localparam int unsigned CntW     = $clog2(NumSteps + 1);
    localparam int unsigned ExtW     = ADDRESS_LEN - 26;
    localparam int unsigned Msb      = DATA_LEN - 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [DATA_LEN-1:0] acc_q, acc_d;
    logic [DATA_LEN-1:0] mcand_q, mcand_d;
    logic [DATA_LEN-1:0] mplier_q, mplier_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                s_q, s_d;
    logic                n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

    logic [DATA_LEN-1:0] alu_res;
    logic [DATA_LEN-1:0] add_b;
    logic                add_cin;
    logic [DATA_LEN:0]   add_sum;
    logic                add_v;
    logic                alu_arith;
    logic                alu_known;
    logic [DATA_LEN-1:0] partial;
    logic                mul_req;
    logic                accept;
    logic                alu_fire;
    logic                mul_fire;

    // Branch target: word offset sign-extended and scaled to bytes.
    assign Branch_Address = PC_in + {{ExtW{Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

    // Combinational ALU; subtraction is a + ~b + cin so C comes out as NOT-borrow.
    always_comb begin
        add_b     = Val2;
        add_cin   = 1'b0;
        alu_arith = 1'b0;
        alu_known = 1'b1;
        alu_res   = '0;
        case (EXE_CMD)
            4'b0010: alu_arith = 1'b1;
            4'b0011: begin alu_arith = 1'b1; add_cin = carry_in; end
            4'b0100: begin alu_arith = 1'b1; add_b = ~Val2; add_cin = 1'b1; end
            4'b0101: begin alu_arith = 1'b1; add_b = ~Val2; add_cin = carry_in; end
            default: ;
        endcase
        add_sum = {1'b0, Val_Rn} + {1'b0, add_b} + {{DATA_LEN{1'b0}}, add_cin};
        add_v   = (Val_Rn[Msb] == add_b[Msb]) && (add_sum[Msb] != Val_Rn[Msb]);
        case (EXE_CMD)
            4'b0001: alu_res = Val2;
            4'b1001: alu_res = ~Val2;
            4'b0010, 4'b0011, 4'b0100, 4'b0101: alu_res = add_sum[DATA_LEN-1:0];
            4'b0110: alu_res = Val_Rn & Val2;
            4'b0111: alu_res = Val_Rn | Val2;
            4'b1000: alu_res = Val_Rn ^ Val2;
            default: alu_known = 1'b0;
        endcase
    end

    // One multiplier step: multiplicand times the low MUL_STEP multiplier bits.
    always_comb begin
        partial = '0;
        for (int i = 0; i < int'(MUL_STEP); i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
    end

    assign mul_req  = is_mul | is_mla;
    assign accept   = (state_q == StIdle) & valid_in & mul_req & ~flush;
    assign alu_fire = (state_q == StIdle) & valid_in & ~mul_req & ~flush;
    assign mul_fire = (state_q == StDone) & ~flush;

    // Next-state logic for the multiply FSM, its datapath and the status flags.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        s_d      = s_q;
        n_d      = n_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    mcand_d  = Val_Rn;
                    mplier_d = Val2;
                    acc_d    = is_mla ? Val_Acc : '0;
                    count_d  = CntW'(NumSteps);
                    s_d      = S;
                    state_d  = StBusy;
                end else if (alu_fire && S && alu_known) begin
                    n_d = alu_res[Msb];
                    z_d = (alu_res == '0);
                    if (alu_arith) begin
                        c_d = add_sum[DATA_LEN];
                        v_d = add_v;
                    end
                end
            end
            StBusy: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d    = acc_q + partial;
                    mcand_d  = mcand_q << MUL_STEP;
                    mplier_d = mplier_q >> MUL_STEP;
                    count_d  = count_q - CntW'(1);
                    if (count_q == CntW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // S was captured at accept; inputs are not looked at here except flush.
                state_d = StIdle;
                if (mul_fire && s_q) begin
                    n_d = acc_q[Msb];
                    z_d = (acc_q == '0);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            s_q      <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            s_q      <= s_d;
            n_q      <= n_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
        end
    end

    // Stall covers the accept cycle plus every BUSY cycle; reset forces both strobes low.
    assign stall     = ~rst & ((state_q == StBusy) | accept);
    assign res_valid = ~rst & (alu_fire | mul_fire);
    assign ALU_Res   = (state_q == StDone) ? acc_q : alu_res;

    assign N_stat = n_q;
    assign Z_stat = z_q;
    assign C_stat = c_q;
    assign V_stat = v_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: ALU vector table plus multiply/flush/reset sequences,
// with a second instance built for four multiplier bits per cycle.
module tb_exe_stage_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, flush, is_mul, is_mla, carry_in, S;
    logic [31:0] PC_in, Val_Rn, Val2, Val_Acc;
    logic [3:0]  EXE_CMD;
    logic [23:0] Signed_imm_24;

    logic [31:0] res1, ba1, res4, ba4;
    logic        rv1, st1, n1, z1, c1, v1;
    logic        rv4, st4, n4, z4, c4, v4;

    int n_applied = 0;
    int n_fail    = 0;

    exe_stage_mc #(.DATA_LEN(32), .ADDRESS_LEN(32), .MUL_STEP(1)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .PC_in(PC_in),
        .EXE_CMD(EXE_CMD), .is_mul(is_mul), .is_mla(is_mla), .Val_Rn(Val_Rn), .Val2(Val2),
        .Val_Acc(Val_Acc), .carry_in(carry_in), .S(S), .Signed_imm_24(Signed_imm_24),
        .ALU_Res(res1), .res_valid(rv1), .stall(st1), .Branch_Address(ba1),
        .N_stat(n1), .Z_stat(z1), .C_stat(c1), .V_stat(v1)
    );

    exe_stage_mc #(.DATA_LEN(32), .ADDRESS_LEN(32), .MUL_STEP(4)) dut4 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush), .PC_in(PC_in),
        .EXE_CMD(EXE_CMD), .is_mul(is_mul), .is_mla(is_mla), .Val_Rn(Val_Rn), .Val2(Val2),
        .Val_Acc(Val_Acc), .carry_in(carry_in), .S(S), .Signed_imm_24(Signed_imm_24),
        .ALU_Res(res4), .res_valid(rv4), .stall(st4), .Branch_Address(ba4),
        .N_stat(n4), .Z_stat(z4), .C_stat(c4), .V_stat(v4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] rn;
        logic [31:0] v2;
        logic        cin;
        logic        s;
        logic [31:0] res;
        logic [3:0]  nzcv;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int sel, output logic [31:0] r, output logic rv,
                          output logic st, output logic [3:0] f);
        if (sel == 4) begin
            r = res4; rv = rv4; st = st4; f = {n4, z4, c4, v4};
        end else begin
            r = res1; rv = rv1; st = st1; f = {n1, z1, c1, v1};
        end
    endtask

    task automatic start_mul(input logic mla, input logic [31:0] rn, input logic [31:0] v2,
                             input logic [31:0] acc);
        valid_in = 1'b1; flush = 1'b0; S = 1'b1; EXE_CMD = 4'b0000;
        is_mul = ~mla; is_mla = mla;
        Val_Rn = rn; Val2 = v2; Val_Acc = acc;
        #1;
    endtask

    // Called in the accept cycle; runs to DONE, checks latency, result and flags.
    task automatic wait_done(input int sel, input string name, input logic [31:0] exp_res,
                             input logic [3:0] exp_f, input int nsteps, input bit drop,
                             input bit flush_done);
        logic [31:0] r;
        logic        rv, st;
        logic [3:0]  f;
        int          stalls = 0;
        int          cyc = 0;
        sample(sel, r, rv, st, f);
        while (st && cyc < 200) begin
            stalls++;
            step();
            cyc++;
            sample(sel, r, rv, st, f);
        end
        chk({name, "_stall_cycles"}, stalls, nsteps + 1);
        if (flush_done) begin
            flush = 1'b1;
            #1;
            sample(sel, r, rv, st, f);
            chk({name, "_flushed_valid"}, rv, 0);
        end else begin
            chk({name, "_valid"}, rv, 1);
            chk({name, "_res"}, r, exp_res);
        end
        if (drop) begin
            is_mul = 1'b0; is_mla = 1'b0;
        end
        step();
        sample(sel, r, rv, st, f);
        chk({name, "_flags"}, f, exp_f);
        flush = 1'b0;
    endtask

    logic [31:0] r;
    logic        rv, st;
    logic [3:0]  f;
    int          bad;

    initial begin
        // cmd, rn, v2, cin, s, res, nzcv (flags carry over from one vector to the next)
        vt[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h80000000, 4'b1001};
        vt[1]  = '{4'b0100, 32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 4'b0110};
        vt[2]  = '{4'b0101, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b1000};
        vt[3]  = '{4'b0001, 32'h12345678, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 4'b0100};
        vt[4]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 4'b0110};
        vt[5]  = '{4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b1, 32'hF000F000, 4'b1010};
        vt[6]  = '{4'b0111, 32'h0000000F, 32'h000000F0, 1'b0, 1'b0, 32'h000000FF, 4'b1010};
        vt[7]  = '{4'b1000, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 1'b1, 32'hF0F00F0F, 4'b1010};
        vt[8]  = '{4'b1001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000, 4'b0110};
        vt[9]  = '{4'b0011, 32'h00000001, 32'h00000002, 1'b1, 1'b1, 32'h00000004, 4'b0000};
        vt[10] = '{4'b0100, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 4'b0011};
        vt[11] = '{4'b0000, 32'h00000005, 32'h00000003, 1'b0, 1'b1, 32'h00000000, 4'b0011};
        vt[12] = '{4'b1111, 32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000000, 4'b0011};
        vt[13] = '{4'b0101, 32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 4'b0010};
        vt[14] = '{4'b0011, 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b1, 32'h80000000, 4'b1001};
        vt[15] = '{4'b0010, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000, 4'b0111};

        rst = 1'b1; valid_in = 1'b1; flush = 1'b0; is_mul = 1'b0; is_mla = 1'b0;
        carry_in = 1'b0; S = 1'b1; EXE_CMD = 4'b0010; Val_Rn = 32'd2; Val2 = 32'd3;
        Val_Acc = 32'd0; PC_in = 32'h100; Signed_imm_24 = 24'hFFFFFE;

        // Reset: strobes low, flags clear, ALU still combinational.
        #12;
        sample(1, r, rv, st, f);
        chk("rst_res", r, 32'd5);
        chk("rst_valid", rv, 0);
        chk("rst_stall", st, 0);
        chk("rst_flags", f, 4'b0000);
        valid_in = 1'b0;
        rst = 1'b0;
        step();

        for (int i = 0; i < 16; i++) begin
            valid_in = 1'b1; EXE_CMD = vt[i].cmd; Val_Rn = vt[i].rn; Val2 = vt[i].v2;
            carry_in = vt[i].cin; S = vt[i].s;
            #1;
            sample(1, r, rv, st, f);
            chk($sformatf("vec%0d_res", i), r, vt[i].res);
            chk($sformatf("vec%0d_valid", i), rv, 1);
            chk($sformatf("vec%0d_stall", i), st, 0);
            step();
            sample(1, r, rv, st, f);
            chk($sformatf("vec%0d_flags", i), f, vt[i].nzcv);
        end

        // Flushed ALU op: no valid, flags held.
        EXE_CMD = 4'b0010; Val_Rn = 32'd1; Val2 = 32'd1; S = 1'b1; flush = 1'b1;
        #1;
        sample(1, r, rv, st, f);
        chk("alu_flush_valid", rv, 0);
        step();
        sample(1, r, rv, st, f);
        chk("alu_flush_flags", f, 4'b0111);
        flush = 1'b0;

        // Not valid: result still combinational, no flag write.
        valid_in = 1'b0; EXE_CMD = 4'b0100; Val_Rn = 32'd0; Val2 = 32'd1;
        #1;
        sample(1, r, rv, st, f);
        chk("novalid_res", r, 32'hFFFFFFFF);
        chk("novalid_valid", rv, 0);
        step();
        sample(1, r, rv, st, f);
        chk("novalid_flags", f, 4'b0111);

        // Multiplies on the one-bit-per-cycle instance; C/V stay 1.
        start_mul(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
        wait_done(1, "mul_ff", 32'h1, 4'b0011, 32, 1'b1, 1'b0);
        start_mul(1'b1, 32'd3, 32'd4, 32'hFFFFFFF6);
        wait_done(1, "mla", 32'd2, 4'b0011, 32, 1'b1, 1'b0);

        // Back-to-back: second accepted in the IDLE cycle right after DONE.
        start_mul(1'b0, 32'h00010000, 32'h00010000, 32'h0);
        wait_done(1, "mul_zero", 32'h0, 4'b0111, 32, 1'b0, 1'b0);
        Val_Rn = 32'hFFFFFFFF; Val2 = 32'd2;
        #1;
        wait_done(1, "mul_b2b", 32'hFFFFFFFE, 4'b1011, 32, 1'b1, 1'b0);

        // Flush on BUSY cycle 10.
        start_mul(1'b0, 32'd7, 32'd7, 32'h0);
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        #1;
        sample(1, r, rv, st, f);
        chk("busy_flush_valid", rv, 0);
        step();
        sample(1, r, rv, st, f);
        chk("busy_flush_idle_stall", st, 0);
        chk("busy_flush_idle_valid", rv, 0);
        is_mul = 1'b0; valid_in = 1'b0; flush = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            sample(1, r, rv, st, f);
            if (rv || st) bad++;
        end
        chk("busy_flush_quiet_cycles", bad, 0);
        chk("busy_flush_flags", f, 4'b1011);

        // Flush in DONE: completion suppressed, flags untouched.
        start_mul(1'b0, 32'd5, 32'd5, 32'h0);
        wait_done(1, "done_flush", 32'd25, 4'b1011, 32, 1'b1, 1'b1);

        // Reset mid-BUSY: immediate abort.
        start_mul(1'b0, 32'd3, 32'd3, 32'h0);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        #1;
        sample(1, r, rv, st, f);
        chk("midrst_stall", st, 0);
        chk("midrst_valid", rv, 0);
        chk("midrst_flags", f, 4'b0000);
        is_mul = 1'b0; valid_in = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Four multiplier bits per cycle: eight BUSY cycles.
        start_mul(1'b1, 32'd3, 32'd4, 32'hFFFFFFF6);
        wait_done(4, "mla_step4", 32'd2, 4'b0000, 8, 1'b1, 1'b0);
        start_mul(1'b0, 32'hFFFFFFFF, 32'd2, 32'h0);
        wait_done(4, "mul_step4", 32'hFFFFFFFE, 4'b1000, 8, 1'b1, 1'b0);

        // Branch adder.
        PC_in = 32'h100; Signed_imm_24 = 24'hFFFFFE;
        #1;
        chk("br_neg", ba1, 32'h000000F8);
        PC_in = 32'h1000; Signed_imm_24 = 24'h000010;
        #1;
        chk("br_pos", ba1, 32'h00001040);
        PC_in = 32'hFFFFFFF0; Signed_imm_24 = 24'h000008;
        #1;
        chk("br_wrap", ba4, 32'h00000010);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
